// File: rtl/ara_dispatch_arbiter.sv
// rtl/ara_dispatch_arbiter.sv - round-robin arbiter sharing the Ara sequencer request/response channel
package ara_dispatch_pkg;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] scalar_op;
  } ara_req_t;

  typedef struct packed {
    logic [31:0] resp;
    logic        error;
  } ara_resp_t;

endpackage

module ara_dispatch_arbiter
  import ara_dispatch_pkg::*;
#(
  parameter int NrReq = 2,
  parameter int IdxW  = $clog2(NrReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ara_req_t  [NrReq-1:0] req_i,
  input  logic      [NrReq-1:0] req_valid_i,
  output logic      [NrReq-1:0] req_ready_o,
  output ara_resp_t [NrReq-1:0] resp_o,
  output logic      [NrReq-1:0] resp_valid_o,
  output ara_req_t              ara_req_o,
  output logic                  ara_req_valid_o,
  input  logic                  ara_req_ready_i,
  input  ara_resp_t             ara_resp_i,
  input  logic                  ara_resp_valid_i,
  output logic      [IdxW-1:0]  grant_idx_o,
  output logic                  locked_o,
  output logic                  idle_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] grant;
  logic            any_valid;
  logic            handshake;

  // Index after x, wrapping at NrReq (NrReq need not be a power of two)
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] x);
    if (int'(x) == NrReq - 1) return '0;
    return x + IdxW'(1);
  endfunction

  // Candidate at distance i from the round-robin pointer
  function automatic logic [IdxW-1:0] cand(input logic [IdxW-1:0] base, input int i);
    return IdxW'((int'(base) + i) % NrReq);
  endfunction

  // Round-robin search: scanning from the far end keeps the candidate closest to rr_ptr_q
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int i = NrReq - 1; i >= 0; i--) begin
      if (req_valid_i[cand(rr_ptr_q, i)]) begin
        any_valid = 1'b1;
        winner    = cand(rr_ptr_q, i);
      end
    end
  end

  // State, pointer and owner registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Next state: lock on a stalled grant, release and advance the pointer on a handshake
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (ara_req_ready_i) begin
            handshake = 1'b1;
            rr_ptr_d  = wrap_inc(winner);
          end else begin
            owner_d = winner;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (ara_req_ready_i && req_valid_i[owner_q]) begin
          handshake = 1'b1;
          rr_ptr_d  = wrap_inc(owner_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pass-through of the granted payload, response steered to the grant; all quiet in reset
  always_comb begin
    req_ready_o     = '0;
    resp_o          = '0;
    resp_valid_o    = '0;
    ara_req_o       = '0;
    ara_req_valid_o = 1'b0;
    grant           = '0;
    locked_o        = 1'b0;
    idle_o          = 1'b1;
    if (!rst_i) begin
      idle_o = (state_q == IDLE) && !(|req_valid_i);
      if (state_q == LOCKED) begin
        grant                = owner_q;
        locked_o             = 1'b1;
        ara_req_o            = req_i[owner_q];
        ara_req_valid_o      = req_valid_i[owner_q];
        req_ready_o[owner_q] = ara_req_ready_i;
      end else if (any_valid) begin
        grant               = winner;
        ara_req_o           = req_i[winner];
        ara_req_valid_o     = 1'b1;
        req_ready_o[winner] = ara_req_ready_i;
      end
      resp_o[grant]       = ara_resp_i;
      resp_valid_o[grant] = ara_resp_valid_i && ara_req_valid_o;
    end
  end

  assign grant_idx_o = grant;

  // The lock owner must keep its request up until the sequencer accepts it
  a_owner_holds_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCKED) |-> req_valid_i[owner_q]);

  // A response with no request on the channel has nowhere to go
  a_resp_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
    ara_resp_valid_i |-> ara_req_valid_o);

endmodule

// File: tb/tb_ara_dispatch_arbiter.sv
// tb/tb_ara_dispatch_arbiter.sv - table, corner-case and randomized checks for ara_dispatch_arbiter
module tb_ara_dispatch_arbiter;
  import ara_dispatch_pkg::*;

  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   rst_i;
  ara_req_t  [N-1:0]      req_i;
  logic      [N-1:0]      req_valid_i;
  logic      [N-1:0]      req_ready_o;
  ara_resp_t [N-1:0]      resp_o;
  logic      [N-1:0]      resp_valid_o;
  ara_req_t               ara_req_o;
  logic                   ara_req_valid_o;
  logic                   ara_req_ready_i;
  ara_resp_t              ara_resp_i;
  logic                   ara_resp_valid_i;
  logic      [1:0]        grant_idx_o;
  logic                   locked_o;
  logic                   idle_o;

  ara_dispatch_arbiter #(.NrReq(N)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o),
    .ara_req_o(ara_req_o), .ara_req_valid_o(ara_req_valid_o), .ara_req_ready_i(ara_req_ready_i),
    .ara_resp_i(ara_resp_i), .ara_resp_valid_i(ara_resp_valid_i),
    .grant_idx_o(grant_idx_o), .locked_o(locked_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       avalid;
    int       grant;
    bit [3:0] ready;
    bit [3:0] rvalid;
    bit       locked;
    bit       idle;
  } exp_t;

  typedef struct {
    bit [3:0] vld;
    bit       rdy;
    bit       rvld;
    exp_t     e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model: pointer to highest-priority requester, and owner (-1 = nobody holds the channel)
  int       m_rr;
  int       m_owner;
  bit [3:0] m_last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_eval(output exp_t e);
    int w;
    w = -1;
    e = '{default: 0};
    if (m_owner >= 0) begin
      e.grant  = m_owner;
      e.avalid = req_valid_i[m_owner];
      e.locked = 1;
      e.ready  = ara_req_ready_i ? 4'(1 << m_owner) : 4'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid_i[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      if (w >= 0) begin
        e.grant  = w;
        e.avalid = 1;
        e.ready  = ara_req_ready_i ? 4'(1 << w) : 4'b0;
      end
    end
    e.rvalid = (e.avalid && ara_resp_valid_i) ? 4'(1 << e.grant) : 4'b0;
    e.idle   = (m_owner < 0) && (req_valid_i == 0);
  endtask

  task automatic model_advance();
    exp_t e;
    model_eval(e);
    m_last_ready = e.ready;
    if (m_owner >= 0) begin
      if (ara_req_ready_i && req_valid_i[m_owner]) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (e.avalid) begin
      if (ara_req_ready_i) m_rr = (e.grant + 1) % N;
      else m_owner = e.grant;
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".avalid"}, ara_req_valid_o, e.avalid);
    chk({tag, ".ready"}, req_ready_o, e.ready);
    chk({tag, ".rvalid"}, resp_valid_o, e.rvalid);
    chk({tag, ".locked"}, locked_o, e.locked);
    chk({tag, ".idle"}, idle_o, e.idle);
    if (e.avalid) begin
      chk({tag, ".grant"}, grant_idx_o, e.grant);
      chk({tag, ".req"}, ara_req_o, req_i[e.grant]);
      chk({tag, ".resp"}, resp_o[e.grant], ara_resp_i);
    end else if (!e.locked) begin
      chk({tag, ".req0"}, ara_req_o, 0);
    end
  endtask

  // inputs are already applied (1 time unit after posedge); sample mid-cycle, then advance
  task automatic step(input string tag, input bit use_tab, input exp_t tab);
    exp_t e;
    #3;
    model_eval(e);
    check_outputs(tag, use_tab ? tab : e);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  vec_t tab[$];
  exp_t e0, rst_e;

  function automatic exp_t mk(bit av, int g, bit [3:0] r, bit [3:0] rv, bit lk, bit id);
    exp_t e;
    e.avalid = av; e.grant = g; e.ready = r; e.rvalid = rv; e.locked = lk; e.idle = id;
    return e;
  endfunction

  initial begin
    // hand-derived sequence from reset (rr=0), NrReq=4
    tab.push_back('{4'b0010, 1, 0, mk(1, 1, 4'b0010, 0, 0, 0)});  // rr -> 2
    tab.push_back('{4'b0011, 1, 0, mk(1, 0, 4'b0001, 0, 0, 0)});  // wrap, rr -> 1
    tab.push_back('{4'b0011, 1, 0, mk(1, 1, 4'b0010, 0, 0, 0)});  // rr -> 2
    tab.push_back('{4'b0011, 0, 0, mk(1, 0, 4'b0000, 0, 0, 0)});  // lock owner 0
    tab.push_back('{4'b0011, 0, 0, mk(1, 0, 4'b0000, 0, 1, 0)});
    tab.push_back('{4'b0011, 0, 0, mk(1, 0, 4'b0000, 0, 1, 0)});
    tab.push_back('{4'b0011, 0, 0, mk(1, 0, 4'b0000, 0, 1, 0)});
    tab.push_back('{4'b0011, 1, 0, mk(1, 0, 4'b0001, 0, 1, 0)});  // owner handshake, rr -> 1
    tab.push_back('{4'b0011, 1, 0, mk(1, 1, 4'b0010, 0, 0, 0)});  // next cycle grants 1, rr -> 2
    tab.push_back('{4'b1101, 1, 0, mk(1, 2, 4'b0100, 0, 0, 0)});  // rr -> 3
    tab.push_back('{4'b1101, 1, 0, mk(1, 3, 4'b1000, 0, 0, 0)});  // rr -> 0
    tab.push_back('{4'b1101, 1, 0, mk(1, 0, 4'b0001, 0, 0, 0)});  // rr -> 1
    tab.push_back('{4'b1101, 1, 0, mk(1, 2, 4'b0100, 0, 0, 0)});  // 1 skipped, rr -> 3
    tab.push_back('{4'b0000, 1, 0, mk(0, 0, 4'b0000, 0, 0, 1)});  // idle
    tab.push_back('{4'b0010, 0, 0, mk(1, 1, 4'b0000, 0, 0, 0)});  // lock owner 1
    tab.push_back('{4'b0010, 0, 0, mk(1, 1, 4'b0000, 0, 1, 0)});
    tab.push_back('{4'b0010, 0, 0, mk(1, 1, 4'b0000, 0, 1, 0)});
    tab.push_back('{4'b0010, 1, 1, mk(1, 1, 4'b0010, 4'b0010, 1, 0)});  // error resp with handshake

    rst_e = mk(0, 0, 4'b0000, 0, 0, 1);
    rst_i = 1'b1;
    req_valid_i = '0;
    ara_req_ready_i = 1'b0;
    ara_resp_valid_i = 1'b0;
    ara_resp_i = '{resp: 32'h0000_1234, error: 1'b1};
    for (int i = 0; i < N; i++) req_i[i] = '{op: 8'(8'hA0 + i), scalar_op: 32'(32'h1000 * (i + 1))};
    m_rr = 0; m_owner = -1; m_last_ready = '0;
    #2;
    check_outputs("reset", rst_e);
    chk("reset.resp_o", resp_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    foreach (tab[r]) begin
      req_valid_i      = tab[r].vld;
      ara_req_ready_i  = tab[r].rdy;
      ara_resp_valid_i = tab[r].rvld;
      step($sformatf("tab%0d", r), 1'b1, tab[r].e);
    end

    // reset while locked on owner 2
    req_valid_i = 4'b0100; ara_req_ready_i = 1'b0; ara_resp_valid_i = 1'b0;
    step("lk2a", 1'b1, mk(1, 2, 4'b0000, 0, 0, 0));
    step("lk2b", 1'b1, mk(1, 2, 4'b0000, 0, 1, 0));
    rst_i = 1'b1;
    #1;
    check_outputs("midrst", rst_e);
    chk("midrst.resp_o", resp_o, 0);
    m_rr = 0; m_owner = -1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    req_valid_i = 4'b0101; ara_req_ready_i = 1'b1;
    step("postrst", 1'b1, mk(1, 0, 4'b0001, 0, 0, 0));

    // randomized traffic from protocol-compliant dispatchers against the model
    req_valid_i = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_last_ready[i]) req_valid_i[i] = 1'b0;
        if (!req_valid_i[i] && $urandom_range(0, 2) == 0) begin
          req_valid_i[i] = 1'b1;
          req_i[i] = '{op: 8'($urandom), scalar_op: $urandom};
        end
      end
      ara_req_ready_i = ($urandom_range(0, 2) != 0);
      ara_resp_i = '{resp: $urandom, error: 1'($urandom)};
      ara_resp_valid_i = 1'b0;
      model_eval(e0);
      ara_resp_valid_i = e0.avalid && ($urandom_range(0, 1) == 1);
      m_last_ready = '0;
      step($sformatf("rnd%0d", c), 1'b0, e0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
